// File: rtl/monitor_step_controller_if.sv
// CPU-side bus bundle for monitor_step_controller: 68000 strobes, address,
// data, the decoder's ready and the DTACK returned to the CPU.
// The master modport is the CPU/decoder side; the slave modport is the
// step controller, which owns DTACK.
interface monitor_step_controller_if;
  logic        AS_IN;
  logic        RW_IN;
  logic        UDS_IN;
  logic        LDS_IN;
  logic [23:0] ADDR_IN;
  logic [15:0] DATA_IN;
  logic        DTACK_REQ_IN;
  logic        DTACK;

  modport master (
    output AS_IN, RW_IN, UDS_IN, LDS_IN, ADDR_IN, DATA_IN, DTACK_REQ_IN,
    input  DTACK
  );

  modport slave (
    input  AS_IN, RW_IN, UDS_IN, LDS_IN, ADDR_IN, DATA_IN, DTACK_REQ_IN,
    output DTACK
  );
endinterface

// File: rtl/monitor_step_controller.sv
// monitor_step_controller: bus-cycle sequencer between the 68000, the memory
// decoder and the SPI debug monitor. It owns DTACK, can hold any bus cycle
// (single-step or address breakpoint) and freezes an address/data/status
// snapshot at the point the cycle is acknowledged by the decoder.
// Build option: define MONITOR_BREAK_EN to include the breakpoint comparator
// and the sticky BREAK_HIT flag; without it halting comes only from CTRL_IN[0].
module monitor_step_controller (
  input  logic                             CLK_IN,
  input  logic                             RESET_IN,
  monitor_step_controller_if.slave         cpu_bus,
  input  logic [7:0]                       CTRL_IN,
  input  logic [23:0]                      BREAK_ADDR_IN,
  output logic [23:0]                      SNAP_ADDR,
  output logic [15:0]                      SNAP_DATA,
  output logic [7:0]                       STATUS
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    HOLD,
    RELEASE
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [2:0]  ctrl_meta;
  logic [2:0]  ctrl_s;
  logic        step_prev;
  logic        halt_prev;
  logic        step_event;
  logic        halt_fall;
  logic        capture;
  logic        break_match;
  logic        break_hit;
  logic        dtack_q;
  logic        halted_q;
  logic        snap_rw;
  logic        snap_uds;
  logic        snap_lds;
  logic        unused_inputs;

  // Bring the monitor command bits into the CPU clock domain and keep the
  // previous STEP/HALT levels for edge detection.
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      ctrl_meta <= 3'b000;
      ctrl_s    <= 3'b000;
      step_prev <= 1'b0;
      halt_prev <= 1'b0;
    end else begin
      ctrl_meta <= CTRL_IN[2:0];
      ctrl_s    <= ctrl_meta;
      step_prev <= ctrl_s[1];
      halt_prev <= ctrl_s[0];
    end
  end

  // A STEP event fires once per toggle; it is only acted upon in HOLD, so a
  // toggle seen in any other state is simply lost.
  assign step_event = ctrl_s[1] ^ step_prev;
  assign halt_fall  = halt_prev & ~ctrl_s[0];
  assign capture    = (state == WAIT_ACK) & ~cpu_bus.AS_IN & ~cpu_bus.DTACK_REQ_IN;

`ifdef MONITOR_BREAK_EN
  assign break_match   = ctrl_s[2] & (cpu_bus.ADDR_IN[23:1] == BREAK_ADDR_IN[23:1]);
  assign unused_inputs = ^{CTRL_IN[7:3], BREAK_ADDR_IN[0]};
`else
  assign break_match   = 1'b0;
  assign unused_inputs = ^{CTRL_IN[7:3], BREAK_ADDR_IN, ctrl_s[2]};
`endif

  // State register for the bus-cycle sequencer.
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; an address-strobe release always wins over a step.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (!cpu_bus.AS_IN) begin
          next_state = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (cpu_bus.AS_IN) begin
          next_state = IDLE;
        end else if (!cpu_bus.DTACK_REQ_IN) begin
          if (ctrl_s[0] || break_match) begin
            next_state = HOLD;
          end else begin
            next_state = RELEASE;
          end
        end
      end
      HOLD: begin
        if (cpu_bus.AS_IN) begin
          next_state = IDLE;
        end else if (step_event || halt_fall) begin
          next_state = RELEASE;
        end
      end
      RELEASE: begin
        if (cpu_bus.AS_IN) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // DTACK and HALTED are registered from the next state so they change on
  // the same edge as the state itself.
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      dtack_q  <= 1'b1;
      halted_q <= 1'b0;
    end else begin
      dtack_q  <= (next_state != RELEASE);
      halted_q <= (next_state == HOLD);
    end
  end

  // Snapshot is taken only on the cycle the decoder acknowledges; strobes are
  // stored as "asserted" flags (1 = strobe active) so STATUS reads naturally.
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      SNAP_ADDR <= 24'h000000;
      SNAP_DATA <= 16'h0000;
      snap_rw   <= 1'b0;
      snap_uds  <= 1'b0;
      snap_lds  <= 1'b0;
    end else if (capture) begin
      SNAP_ADDR <= cpu_bus.ADDR_IN;
      SNAP_DATA <= cpu_bus.DATA_IN;
      snap_rw   <= cpu_bus.RW_IN;
      snap_uds  <= ~cpu_bus.UDS_IN;
      snap_lds  <= ~cpu_bus.LDS_IN;
    end
  end

  // Sticky breakpoint flag: set on a matching capture, cleared when the held
  // cycle is released or when breakpoints are disabled.
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      break_hit <= 1'b0;
    end else if (!ctrl_s[2] || (state == HOLD && next_state == RELEASE)) begin
      break_hit <= 1'b0;
    end else if (capture && break_match) begin
      break_hit <= 1'b1;
    end
  end

  assign cpu_bus.DTACK = dtack_q;
  assign STATUS        = {3'b000, break_hit, snap_lds, snap_uds, snap_rw, halted_q};

endmodule

// File: tb/tb_monitor_step_controller.sv
// Testbench for monitor_step_controller. Stimulus pushes expected DTACK-fall
// and HALTED-rise events (with the cycle they must occur on and the snapshot
// they must show) and expected steady-state probes into queues; a separate
// monitor process pops and compares them. Honors MONITOR_BREAK_EN.
module tb_monitor_step_controller;

  localparam int EV_ACK  = 0;
  localparam int EV_HALT = 1;

  typedef struct {
    int          kind;
    int          cyc;
    logic [23:0] addr;
    logic [15:0] data;
    logic [7:0]  status;
  } ev_t;

  typedef struct {
    int          id;
    logic        dtack;
    logic [23:0] addr;
    logic [15:0] data;
    logic [7:0]  status;
  } probe_t;

  logic        clk;
  logic        rst;
  logic [7:0]  ctrl;
  logic [23:0] break_addr;
  logic [23:0] snap_addr;
  logic [15:0] snap_data;
  logic [7:0]  status;

  int          cyc;
  int          tests_run;
  int          tests_failed;
  int          probe_id;
  logic        done;
  ev_t         ev_q[$];
  probe_t      probe_q[$];

  monitor_step_controller_if cpu ();

  monitor_step_controller dut (
    .CLK_IN        (clk),
    .RESET_IN      (rst),
    .cpu_bus       (cpu),
    .CTRL_IN       (ctrl),
    .BREAK_ADDR_IN (break_addr),
    .SNAP_ADDR     (snap_addr),
    .SNAP_DATA     (snap_data),
    .STATUS        (status)
  );

  // Free-running clock and cycle counter.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Absolute time limit so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportEvent(input int kind);
    ev_t e;
    string tag;
    tag = (kind == EV_ACK) ? "ack" : "halt";
    if (ev_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL unexpected_%s: got event at cycle %0d, expected none", tag, cyc);
    end else begin
      e = ev_q.pop_front();
      checkOutput({tag, "_kind"},   kind,      e.kind);
      checkOutput({tag, "_cycle"},  cyc,       e.cyc);
      checkOutput({tag, "_addr"},   snap_addr, {8'h00, e.addr});
      checkOutput({tag, "_data"},   snap_data, {16'h0000, e.data});
      checkOutput({tag, "_status"}, status,    {24'h0, e.status});
    end
  endtask

  // Monitor: compares queued probes and every DTACK-fall / HALTED-rise event.
  initial begin
    logic   prev_dtack;
    logic   prev_halt;
    probe_t p;
    prev_dtack = 1'b1;
    prev_halt  = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      while (probe_q.size() > 0) begin
        p = probe_q.pop_front();
        checkOutput($sformatf("probe%0d_dtack", p.id),  cpu.DTACK, {31'h0, p.dtack});
        checkOutput($sformatf("probe%0d_addr", p.id),   snap_addr, {8'h00, p.addr});
        checkOutput($sformatf("probe%0d_data", p.id),   snap_data, {16'h0000, p.data});
        checkOutput($sformatf("probe%0d_status", p.id), status,    {24'h0, p.status});
      end
      if (prev_dtack === 1'b1 && cpu.DTACK === 1'b0) reportEvent(EV_ACK);
      if (prev_halt === 1'b0 && status[0] === 1'b1) reportEvent(EV_HALT);
      prev_dtack = cpu.DTACK;
      prev_halt  = status[0];
      if (done) begin
        checkOutput("pending_events", ev_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [23:0] addr, input logic [15:0] data,
                               input logic rw);
    cpu.ADDR_IN = addr;
    cpu.DATA_IN = data;
    cpu.RW_IN   = rw;
    cpu.UDS_IN  = 1'b0;
    cpu.LDS_IN  = 1'b0;
    cpu.AS_IN   = 1'b0;
  endtask

  task automatic endCycle();
    cpu.AS_IN        = 1'b1;
    cpu.UDS_IN       = 1'b1;
    cpu.LDS_IN       = 1'b1;
    cpu.DTACK_REQ_IN = 1'b1;
  endtask

  task automatic expectEvent(input int kind, input int at, input logic [23:0] addr,
                             input logic [15:0] data, input logic [7:0] st);
    ev_t e;
    e.kind = kind; e.cyc = at; e.addr = addr; e.data = data; e.status = st;
    ev_q.push_back(e);
  endtask

  task automatic expectState(input logic dt, input logic [23:0] addr,
                             input logic [15:0] data, input logic [7:0] st);
    probe_t p;
    p.id = probe_id; p.dtack = dt; p.addr = addr; p.data = data; p.status = st;
    probe_id++;
    probe_q.push_back(p);
  endtask

  // Directed stimulus sequence.
  initial begin
    cyc = 0; tests_run = 0; tests_failed = 0; probe_id = 0; done = 1'b0;
    rst = 1'b1; ctrl = 8'h00; break_addr = 24'h0;
    cpu.AS_IN = 1'b1; cpu.RW_IN = 1'b1; cpu.UDS_IN = 1'b1; cpu.LDS_IN = 1'b1;
    cpu.ADDR_IN = 24'h0; cpu.DATA_IN = 16'h0; cpu.DTACK_REQ_IN = 1'b1;
    tick(2);
    expectState(1'b1, 24'h0, 16'h0, 8'h00);
    rst = 1'b0;
    tick(2);

    $display("[TB] run-mode read, then reset while in RELEASE");
    applyStimulus(24'h00FC04, 16'h4E71, 1'b1);
    tick(2);
    cpu.DTACK_REQ_IN = 1'b0;
    expectEvent(EV_ACK, cyc + 1, 24'h00FC04, 16'h4E71, 8'h0E);
    tick(3);
    rst = 1'b1;
    endCycle();
    tick(2);
    expectState(1'b1, 24'h0, 16'h0, 8'h00);
    rst = 1'b0;
    tick(2);

    $display("[TB] step mode write held, then released by STEP toggle");
    ctrl = 8'h01;
    tick(3);
    applyStimulus(24'h001000, 16'hBEEF, 1'b0);
    tick(2);
    cpu.DTACK_REQ_IN = 1'b0;
    expectEvent(EV_HALT, cyc + 1, 24'h001000, 16'hBEEF, 8'h0D);
    tick(1);
    for (int i = 0; i < 10; i++) begin
      tick(10);
      expectState(1'b1, 24'h001000, 16'hBEEF, 8'h0D);
    end
    ctrl = 8'h03;
    expectEvent(EV_ACK, cyc + 3, 24'h001000, 16'hBEEF, 8'h0C);
    tick(5);
    endCycle();
    tick(3);

    $display("[TB] toggle outside HOLD must not pre-arm the next cycle");
    ctrl = 8'h01;
    tick(5);
    expectState(1'b1, 24'h001000, 16'hBEEF, 8'h0C);
    applyStimulus(24'h001002, 16'h1234, 1'b0);
    tick(2);
    cpu.DTACK_REQ_IN = 1'b0;
    expectEvent(EV_HALT, cyc + 1, 24'h001002, 16'h1234, 8'h0D);
    tick(4);

    $display("[TB] abort in HOLD coinciding with a STEP event");
    ctrl = 8'h03;
    tick(2);
    endCycle();
    tick(6);
    expectState(1'b1, 24'h001002, 16'h1234, 8'h0C);

    $display("[TB] abort in WAIT_ACK");
    ctrl = 8'h00;
    tick(3);
    applyStimulus(24'h002000, 16'hAAAA, 1'b1);
    tick(2);
    endCycle();
    tick(4);
    expectState(1'b1, 24'h001002, 16'h1234, 8'h0C);

    $display("[TB] breakpoint at 0x000400, then 0x000402 runs through");
    ctrl = 8'h04;
    break_addr = 24'h000401;
    tick(3);
    applyStimulus(24'h000400, 16'h1111, 1'b1);
    tick(2);
    cpu.DTACK_REQ_IN = 1'b0;
`ifdef MONITOR_BREAK_EN
    expectEvent(EV_HALT, cyc + 1, 24'h000400, 16'h1111, 8'h1F);
    tick(5);
    expectState(1'b1, 24'h000400, 16'h1111, 8'h1F);
    ctrl = 8'h06;
    expectEvent(EV_ACK, cyc + 3, 24'h000400, 16'h1111, 8'h0E);
`else
    expectEvent(EV_ACK, cyc + 1, 24'h000400, 16'h1111, 8'h0E);
`endif
    tick(5);
    endCycle();
    tick(3);
    applyStimulus(24'h000402, 16'h2222, 1'b1);
    tick(2);
    cpu.DTACK_REQ_IN = 1'b0;
    expectEvent(EV_ACK, cyc + 1, 24'h000402, 16'h2222, 8'h0E);
    tick(3);
    endCycle();
    tick(5);

    done = 1'b1;
    forever @(negedge clk);
  end

endmodule

// File: doc/monitor_step_controller.md
# monitor_step_controller

Bus-cycle sequencer between the 68000, the memory decoder and the SPI debug monitor. It owns the CPU's DTACK. It can halt the CPU on any bus cycle, either per the monitor's single-step command or on an address breakpoint. At the halt point it freezes an address/data/status snapshot for the monitor to shift out over SPI.

## Interface
Parameters:
- none.

Ports:
- CLK_IN  in  1  system clock; every input is synchronous to it except CTRL_IN.
- RESET_IN  in  1  reset; synchronous, active-high.
- AS_IN  in  1  CPU address strobe, active-low.
- RW_IN  in  1  CPU read/write (1 = read).
- UDS_IN, LDS_IN  in  1 each  CPU data strobes, active-low.
- ADDR_IN  in  24  CPU address.
- DATA_IN  in  16  CPU data bus: write data from the CPU, or read data from memory.
- DTACK_REQ_IN  in  1  decoder "ready", active-low.
- CTRL_IN  in  8  monitor command byte, asynchronous (SPI domain).
  - bit0 HALT: 1 = step mode.
  - bit1 STEP: toggle; each change releases one cycle.
  - bit2 BREAK_ENABLE.
  - bits 7:3 reserved.
- BREAK_ADDR_IN  in  24  breakpoint address; bit0 is ignored.
- DTACK  out  1  to the CPU, active-low.
- SNAP_ADDR  out  24  captured address.
- SNAP_DATA  out  16  captured data.
- STATUS  out  8  status byte for the monitor.
  - bit0 HALTED.
  - bit1 captured RW.
  - bit2 captured UDS.
  - bit3 captured LDS.
  - bit4 BREAK_HIT.
  - bits 7:5 = 0.

## Operation
CTRL_IN handling:
- Passes through a 2-flop synchronizer. The synchronized value is CTRL_S.
- A STEP event occurs when CTRL_S[1] differs from its previous registered value.

FSM states: IDLE, WAIT_ACK, HOLD, RELEASE.
- IDLE: DTACK = 1. On AS_IN == 0, go to WAIT_ACK.
- WAIT_ACK: wait for DTACK_REQ_IN == 0.
  - On that cycle, capture ADDR_IN, DATA_IN, RW_IN, UDS_IN and LDS_IN into the SNAP regs.
  - If CTRL_S[0] == 1 or a break match occurs, go to HOLD. Otherwise go to RELEASE.
  - If AS_IN returns to 1 first (aborted or bus-error cycle), go to IDLE with no capture.
- HOLD: STATUS[0] = 1 and DTACK = 1.
  - A STEP event, or CTRL_S[0] falling to 0, goes to RELEASE.
  - AS_IN == 1 (external abort) goes to IDLE. The snapshot is kept.
- RELEASE: DTACK = 0. Hold until AS_IN == 1, then go to IDLE with DTACK = 1.

Break match:
- Condition: CTRL_S[2] == 1 and ADDR_IN[23:1] == BREAK_ADDR_IN[23:1], evaluated in the capture cycle.
- Sets BREAK_HIT (sticky).
- BREAK_HIT clears on the HOLD→RELEASE transition or when CTRL_S[2] == 0.

Snapshot rules:
- SNAP_* change only in capture cycles; they stay stable at all other times, including in HOLD.
- STATUS[3:1] come from the captured values.

Simultaneous events:
- A STEP event that arrives outside HOLD is consumed and discarded; it does not pre-arm the next cycle.
- HOLD with a STEP event and AS_IN == 1 in the same cycle goes to IDLE (abort wins).

Reset:
- Takes effect in any state: go to IDLE.
- DTACK = 1, SNAP_ADDR = 0, SNAP_DATA = 0, STATUS = 0.
- Synchronizer flops and the previous-STEP register = 0.

## Timing
- Run mode: DTACK falls 1 clock after the first clock on which DTACK_REQ_IN is sampled low.
- DTACK rises 1 clock after AS_IN is sampled high.
- CTRL_IN to effect is 2 clocks of synchronizer plus 1 clock for edge detect. A STEP toggle therefore drops DTACK 3 clocks after it is stable at CTRL_IN.
- HALTED (STATUS[0]) is asserted from the clock HOLD is entered to the clock HOLD is left.
- At most one bus cycle is released per STEP event.
- All outputs are registered; there are no combinational input→output paths.

## Configuration
- MONITOR_BREAK_EN defined: breakpoint comparator and BREAK_HIT logic are present, as described above.
- MONITOR_BREAK_EN undefined:
  - No comparator is built.
  - BREAK_ADDR_IN and CTRL_IN[2] are ignored.
  - STATUS[4] is tied to 0.
  - Halting occurs only via CTRL_IN[0].

## Test plan
- Reset: hold RESET_IN high for 2 clocks during a cycle in RELEASE → DTACK = 1, SNAP_ADDR = 0, SNAP_DATA = 0, STATUS = 0, state IDLE.
- Run mode, read:
  - Stimulus: CTRL_IN = 0x00, AS_IN low, ADDR_IN = 0x00FC04, DTACK_REQ_IN low on clock 3, DATA_IN = 0x4E71.
  - Expect: DTACK low on clock 4; SNAP_ADDR = 0x00FC04, SNAP_DATA = 0x4E71, STATUS = 0x0E.
- Step mode:
  - Stimulus: CTRL_IN = 0x01, write to 0x001000 with data 0xBEEF.
  - Expect: the FSM stays in HOLD with DTACK = 1 and STATUS = 0x0D for 100 clocks. Toggling bit1 (CTRL_IN = 0x03) gives DTACK low 3 clocks later.
  - A second toggle issued outside HOLD releases nothing.
- Breakpoint:
  - Stimulus: CTRL_IN = 0x04, BREAK_ADDR_IN = 0x000401, cycle at 0x000400.
  - Expect: HOLD, STATUS[4] = 1. A cycle at 0x000402 runs through without halting.
  - With MONITOR_BREAK_EN undefined, the cycle at 0x000400 is not halted.
- Abort:
  - AS_IN rises in WAIT_ACK → IDLE, SNAP unchanged, DTACK never asserted.
  - AS_IN rises in HOLD together with a STEP toggle → IDLE, DTACK stays 1.
